// File: rtl/dti_pack.sv
// Shared definitions for the DTI TNIU request arbiter.
//   arb_state_e : arbiter FSM state (ARB = no open packet, PKT = packet locked)
//   PLD_W/ID_W  : default payload and srcid/tgtid widths of a beat
//   LAST_W/QOS_W: widths of the per-beat last and QoS flags
package dti_pack;

  typedef enum logic {
    ARB = 1'b0,
    PKT = 1'b1
  } arb_state_e;

  localparam int PLD_W  = 90;
  localparam int ID_W   = 6;
  localparam int LAST_W = 1;
  localparam int QOS_W  = 1;

endpackage

// File: rtl/dti_rr_pick.sv
// Round-robin picker: returns a one-hot grant for the first set request bit
// at or after i_ptr, wrapping modulo N.
//   i_req : request mask
//   i_ptr : round-robin start index (always < N)
//   o_gnt : one-hot grant, all-zero when i_req is empty
module dti_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  logic [2*N-1:0] w_req_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_rot_oh;
  logic [2*N-1:0] w_gnt_dbl;

  // Rotate the mask so the pointer position lands on bit 0; the doubled
  // vector makes the wrap-around fall out of a plain shift.
  assign w_req_dbl = {i_req, i_req};
  assign w_rot     = N'(w_req_dbl >> i_ptr);

  // Isolate the lowest set bit of the rotated mask.
  assign w_rot_oh  = w_rot & ~(w_rot - N'(1));

  // Rotate back and fold the upper half onto the lower half.
  assign w_gnt_dbl = {{N{1'b0}}, w_rot_oh} << i_ptr;
  assign o_gnt     = w_gnt_dbl[N-1:0] | w_gnt_dbl[2*N-1:N];

endmodule

// File: rtl/dti_tniu_req_arbiter.sv
// DTI TNIU request arbiter: merges NUM_REQ beat streams into one registered
// output slot feeding the async FIFO slave. Packets are never interleaved;
// QoS requesters win arbitration over non-QoS ones, round-robin within class.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_vld/in_last/in_qos/in_pld/
//   in_srcid/in_tgtid, in_rdy     : per-requester beat handshake and fields
//   out_vld/out_last/out_qos/
//   out_pld/out_srcid/out_tgtid   : merged beat (registered slot)
//   out_rdy                       : downstream accept
//   stall                         : low-power stall, blocks new grants only
//   idle                          : no beat held and no packet open
module dti_tniu_req_arbiter
  import dti_pack::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PLD_WIDTH = PLD_W,
  parameter int ID_WIDTH  = ID_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 in_vld,
  input  logic [NUM_REQ-1:0]                 in_last,
  input  logic [NUM_REQ-1:0]                 in_qos,
  input  logic [NUM_REQ-1:0][PLD_WIDTH-1:0]  in_pld,
  input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]   in_srcid,
  input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]   in_tgtid,
  output logic [NUM_REQ-1:0]                 in_rdy,
  output logic                               out_vld,
  output logic                               out_last,
  output logic                               out_qos,
  output logic [PLD_WIDTH-1:0]               out_pld,
  output logic [ID_WIDTH-1:0]                out_srcid,
  output logic [ID_WIDTH-1:0]                out_tgtid,
  input  logic                               out_rdy,
  input  logic                               stall,
  output logic                               idle
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e           r_state;
  logic                 r_run;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     r_gnt_idx;
  logic                 r_slot_vld;
  logic [LAST_W-1:0]    r_out_last;
  logic [QOS_W-1:0]     r_out_qos;
  logic [PLD_WIDTH-1:0] r_out_pld;
  logic [ID_WIDTH-1:0]  r_out_srcid;
  logic [ID_WIDTH-1:0]  r_out_tgtid;

  logic                 w_slot_accept;
  logic                 w_any_qos;
  logic                 w_xfer;
  logic                 w_sel_last;
  logic [NUM_REQ-1:0]   w_qos_req;
  logic [NUM_REQ-1:0]   w_qos_gnt;
  logic [NUM_REQ-1:0]   w_all_gnt;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [NUM_REQ-1:0]   w_sel_oh;
  logic [PTR_W-1:0]     w_sel_idx;
  logic [PTR_W-1:0]     w_next_ptr;

  assign w_slot_accept = ~r_slot_vld | out_rdy;
  assign w_qos_req     = in_vld & in_qos;
  assign w_any_qos     = |w_qos_req;

  dti_rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_qos (
    .i_req (w_qos_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_qos_gnt)
  );

  dti_rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_all (
    .i_req (in_vld),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_all_gnt)
  );

  assign w_win_oh = w_any_qos ? w_qos_gnt : w_all_gnt;

  // An open packet owns the port regardless of stall, QoS or its own valid.
  always_comb begin
    w_sel_oh = '0;
    if (r_state == PKT) begin
      w_sel_oh[r_gnt_idx] = 1'b1;
    end else if (!stall) begin
      w_sel_oh = w_win_oh;
    end
  end

  always_comb begin
    w_sel_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_sel_oh[k]) w_sel_idx = PTR_W'(k);
    end
  end

  // r_run keeps every in_rdy low while reset is held, since the slot and
  // FSM are already in their accepting state at that point.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rdy
    assign in_rdy[gi] = w_sel_oh[gi] & w_slot_accept & r_run;
  end

  assign w_xfer     = |(in_vld & in_rdy);
  assign w_sel_last = in_last[w_sel_idx];
  // Explicit wrap so non-power-of-two NUM_REQ never points past the last port.
  assign w_next_ptr = (w_sel_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                         : w_sel_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB;
      r_run       <= 1'b0;
      r_rr_ptr    <= '0;
      r_gnt_idx   <= '0;
      r_slot_vld  <= 1'b0;
      r_out_last  <= '0;
      r_out_qos   <= '0;
      r_out_pld   <= '0;
      r_out_srcid <= '0;
      r_out_tgtid <= '0;
    end else begin
      r_run <= 1'b1;

      if (w_xfer) begin
        r_slot_vld  <= 1'b1;
        r_out_last  <= in_last[w_sel_idx];
        r_out_qos   <= in_qos[w_sel_idx];
        r_out_pld   <= in_pld[w_sel_idx];
        r_out_srcid <= in_srcid[w_sel_idx];
        r_out_tgtid <= in_tgtid[w_sel_idx];
      end else if (out_rdy) begin
        r_slot_vld  <= 1'b0;
      end

      case (r_state)
        ARB: begin
          if (w_xfer) begin
            if (w_sel_last) begin
              r_rr_ptr <= w_next_ptr;
            end else begin
              r_state   <= PKT;
              r_gnt_idx <= w_sel_idx;
            end
          end
        end
        PKT: begin
          if (w_xfer && w_sel_last) begin
            r_state  <= ARB;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign out_vld   = r_slot_vld;
  assign out_last  = r_out_last;
  assign out_qos   = r_out_qos;
  assign out_pld   = r_out_pld;
  assign out_srcid = r_out_srcid;
  assign out_tgtid = r_out_tgtid;
  assign idle      = (r_state == ARB) & ~r_slot_vld;

endmodule

// File: doc/dti_tniu_req_arbiter.md
DTI_TNIU_REQ_ARBITER -- requirements
Module: dti_tniu_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester ports, legal range 2..8.
REQ-002 Parameter PLD_WIDTH, default 90: payload width, matching CUSTOM_DATA_WIDTH+CUSTOM_KEEP_WIDTH.
REQ-003 Parameter ID_WIDTH, default 6: srcid/tgtid width, matching TBU_NUM_WIDTH.
REQ-004 Port clk  in  1: single clock; the block has one clock and shares it with the async FIFO slave side.
REQ-005 Port rst_n  in  1: reset, asynchronous and active-low.
REQ-006 Ports in_vld/in_last/in_qos  in  NUM_REQ: per-requester beat valid, packet last, and QoS priority bit.
REQ-007 Ports in_pld  in  NUM_REQ x PLD_WIDTH, and in_srcid/in_tgtid  in  NUM_REQ x ID_WIDTH: per-requester beat fields.
REQ-008 Port in_rdy  out  NUM_REQ: per-requester beat accept.
REQ-009 Ports out_vld/out_last/out_qos  out  1, out_pld  out  PLD_WIDTH, out_srcid/out_tgtid  out  ID_WIDTH: merged beat to the async FIFO slave.
REQ-010 Port out_rdy  in  1: downstream accept.
REQ-011 Port stall  in  1: low-power stall request from the LP async bridge.
REQ-012 Port idle  out  1: the block holds no beat and no packet is open.

Function
REQ-013 A beat transfers on any port when vld and rdy are both high in the same cycle.
REQ-014 Output stage SHALL be a single registered slot; the slot accepts a beat when empty or when out_rdy=1.
REQ-015 Latency from an accepted input beat to out_vld SHALL be exactly 1 cycle; sustained throughput is 1 beat/cycle.
REQ-016 The FSM SHALL have two states: ARB (no open packet) and PKT (packet locked to grant index g).
REQ-017 ARB with stall=0 and any in_vld set: select a winner from requesters with in_qos=1 if any is valid, otherwise from all valid requesters.
REQ-018 Within the selected class, the winner is the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-019 ARB with stall=1: no new grant is issued and all in_rdy are 0.
REQ-020 in_rdy[i]=1 only for the current winner or the locked index, and only when the output slot accepts; every other in_rdy is 0.
REQ-021 Accepted beat with in_last=0 in ARB: go to PKT with g=winner.
REQ-022 Accepted beat with in_last=1 in ARB (single-beat packet): stay in ARB and set rr_ptr=(winner+1) mod NUM_REQ.
REQ-023 In PKT, only requester g is served; stall and in_qos of other ports are ignored until the packet ends.
REQ-024 Accepted in_last=1 from g in PKT: return to ARB and set rr_ptr=(g+1) mod NUM_REQ.
REQ-025 rr_ptr and g SHALL each be $clog2(NUM_REQ) bits wide; for non-power-of-two NUM_REQ the increment wraps explicitly.
REQ-026 All output fields SHALL be copied unmodified from the granted beat; no beat from another requester is interleaved into an open packet.
REQ-027 Withdrawal of in_vld by a non-granted requester has no effect; withdrawal by g in PKT leaves the block in PKT.
REQ-028 idle=1 when state=ARB and the output slot is empty; idle is a registered-state function with no combinational path from inputs.

Reset
REQ-029 Asynchronous reset SHALL force: state=ARB, rr_ptr=0, g=0, slot empty, out_vld=0, all out fields=0, idle=1, all in_rdy=0.
REQ-030 A beat held in the slot or a packet open when rst_n asserts SHALL be discarded; no partial-packet recovery.

Structure
REQ-031 The state enum (ARB, PKT) and the beat field widths (90/6/6/1/1) SHALL live in dti_pack.
REQ-032 Round-robin selection SHALL be one sub-module, dti_rr_pick (inputs: request mask and pointer; output: one-hot grant), instantiated twice, for the QoS and the all-valid class.

Verification
REQ-033 Requesters 0..3 each send a 1-beat packet continuously, qos=0, out_rdy=1 -> output srcid order 0,1,2,3,0, one beat per cycle.
REQ-034 Requester 1 sends a 4-beat packet while 0 and 2 are valid -> four consecutive beats from 1, then requester 2 is granted.
REQ-035 Requesters 0 (qos=0) and 3 (qos=1) both valid, rr_ptr=0 -> requester 3 is granted first.
REQ-036 stall=1 asserted mid-packet on beat 2 of 4 -> beats 3 and 4 complete; no further grant while stall=1; idle=1 after out_rdy drains the slot.
REQ-037 out_rdy=0 for 5 cycles with the slot full -> out_vld stays 1, fields stable, all in_rdy=0.
REQ-038 rst_n pulsed low mid-packet -> next cycle out_vld=0, idle=1, rr_ptr=0; the first grant after reset goes to requester 0.
